wb_port_arbiter: RTL and testbench

- Shares the general-register file's single write port (4-bit byte enable, 5-bit address, 32-bit data) between two requesters:
  - the in-order pipeline writeback stage (P);
  - the long-latency multiply/divide/load-return unit (L).
- Fixed priority to P, with a starvation guard that forces an L grant after a bounded wait.
- Output is registered and drives the register file write port directly; ID-stage forwarding logic also snoops it.

---
 rtl/wb_port_arbiter.sv | 89 ++++++++
 tb/tb_wb_port_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage (P) and the
// long-latency unit (L): fixed priority to P, with a starvation guard for L.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        p_valid,
   output logic        p_ready,
   input  logic [3:0]  p_we,
   input  logic [4:0]  p_waddr,
   input  logic [31:0] p_wdata,
   input  logic        l_valid,
   output logic        l_ready,
   input  logic [3:0]  l_we,
   input  logic [4:0]  l_waddr,
   input  logic [31:0] l_wdata,
   output logic [3:0]  rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        grant_l,
   output logic        starving
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [3:0]       rf_we_q, rf_we_d;
   logic [4:0]       rf_waddr_q, rf_waddr_d;
   logic [31:0]      rf_wdata_q, rf_wdata_d;
   logic             grant_l_q, grant_l_d;
   logic             p_xfer, l_xfer;

   assign starving = (starve_cnt_q == LIMIT);
   assign p_ready  = !(starving && l_valid);
   assign l_ready  = l_valid && (!p_valid || starving);
   assign p_xfer   = p_valid && p_ready;
   assign l_xfer   = l_ready;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!l_valid || l_xfer) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // Writes to r0 and empty byte masks are consumed but never reach the file.
   always_comb begin
      rf_we_d    = 4'h0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      grant_l_d  = 1'b0;
      if (l_xfer) begin
         rf_we_d    = (l_waddr == 5'd0) ? 4'h0 : l_we;
         rf_waddr_d = l_waddr;
         rf_wdata_d = l_wdata;
         grant_l_d  = 1'b1;
      end else if (p_xfer) begin
         rf_we_d    = (p_waddr == 5'd0) ? 4'h0 : p_we;
         rf_waddr_d = p_waddr;
         rf_wdata_d = p_wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt_q <= '0;
         rf_we_q      <= 4'h0;
         rf_waddr_q   <= 5'd0;
         rf_wdata_q   <= 32'd0;
         grant_l_q    <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         grant_l_q    <= grant_l_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign grant_l  = grant_l_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes hand-derived expected
// register outputs into a queue, a monitor pops and compares each cycle.
module tb_wb_port_arbiter;

   logic        clk;
   logic        resetn;
   logic        p_valid, l_valid;
   logic        p_ready, l_ready;
   logic [3:0]  p_we, l_we;
   logic [4:0]  p_waddr, l_waddr;
   logic [31:0] p_wdata, l_wdata;
   logic [3:0]  rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        grant_l;
   logic        starving;

   int n_checks = 0;
   int n_fail   = 0;

   // {grant_l, rf_we, rf_waddr, rf_wdata}
   logic [41:0] exp_q[$];
   logic [4:0]  hold_a;
   logic [31:0] hold_d;

   wb_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
      .clk(clk), .resetn(resetn),
      .p_valid(p_valid), .p_ready(p_ready), .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
      .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_waddr(l_waddr), .l_wdata(l_wdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .grant_l(grant_l), .starving(starving)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the registered output after every edge is compared with the queue head.
   initial begin
      logic [41:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_out", {grant_l, rf_we, rf_waddr, rf_wdata}, e);
         end
      end
   end

   // One cycle of stimulus; epr/elr/est are the hand-computed ready/starving values.
   task automatic cyc(input logic pv, input logic [3:0] pwe, input logic [4:0] pa,
                      input logic [31:0] pd, input logic lv, input logic [3:0] lwe,
                      input logic [4:0] la, input logic [31:0] ld,
                      input logic epr, input logic elr, input logic est);
      logic [41:0] e;
      p_valid = pv; p_we = pwe; p_waddr = pa; p_wdata = pd;
      l_valid = lv; l_we = lwe; l_waddr = la; l_wdata = ld;
      @(negedge clk);
      chk("p_ready", 42'(p_ready), 42'(epr));
      chk("l_ready", 42'(l_ready), 42'(elr));
      chk("starving", 42'(starving), 42'(est));
      if (lv && elr) begin
         hold_a = la; hold_d = ld;
         e = {1'b1, (la == 5'd0) ? 4'h0 : lwe, la, ld};
      end else if (pv && epr) begin
         hold_a = pa; hold_d = pd;
         e = {1'b0, (pa == 5'd0) ? 4'h0 : pwe, pa, pd};
      end else begin
         e = {1'b0, 4'h0, hold_a, hold_d};
      end
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cyc(1'b0, 4'h0, 5'd0, 32'd0, 1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] pdat, ldat;
      logic        st;
      resetn = 1'b0;
      p_valid = 1'b0; p_we = 4'h0; p_waddr = 5'd0; p_wdata = 32'd0;
      l_valid = 1'b0; l_we = 4'h0; l_waddr = 5'd0; l_wdata = 32'd0;
      hold_a = 5'd0; hold_d = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", {grant_l, rf_we, rf_waddr, rf_wdata}, 42'd0);
      chk("reset_ready", {40'd0, p_ready, l_ready}, {40'd0, 2'b10});
      chk("reset_starving", 42'(starving), 42'd0);
      #1;
      resetn = 1'b1;

      // P alone, full word
      cyc(1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      // P partial write: lane pattern preserved
      cyc(1'b1, 4'b0011, 5'd9, 32'h12345678, 1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      // L alone to r0: consumed, no write, grant_l still set
      cyc(1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 4'hF, 5'd0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
      // P with empty byte mask
      cyc(1'b1, 4'h0, 5'd10, 32'h00000055, 1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      idle();
      // L alone partial write
      cyc(1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 4'b1100, 5'd12, 32'h0BADCAFE, 1'b1, 1'b1, 1'b0);

      // P and L both valid to the same address: P x4 then forced L grant, repeating
      pdat = 32'hA0000000; ldat = 32'hB0000000;
      for (int i = 0; i < 10; i++) begin
         st = ((i % 5) == 4);
         cyc(1'b1, 4'hF, 5'd7, pdat, 1'b1, 4'hF, 5'd7, ldat, !st, st, st);
         if (st) ldat = ldat + 1;
         else    pdat = pdat + 1;
      end

      // L refused 3 cycles, drops for one, then needs 4 fresh refusals
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 4'hF, 5'd4, pdat, 1'b1, 4'hF, 5'd6, ldat, 1'b1, 1'b0, 1'b0);
         pdat = pdat + 1;
      end
      cyc(1'b1, 4'hF, 5'd4, pdat, 1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      pdat = pdat + 1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 4'hF, 5'd4, pdat, 1'b1, 4'hF, 5'd6, ldat, 1'b1, 1'b0, 1'b0);
         pdat = pdat + 1;
      end
      cyc(1'b1, 4'hF, 5'd4, pdat, 1'b1, 4'hF, 5'd6, ldat, 1'b0, 1'b1, 1'b1);
      idle();

      // Asynchronous reset while a full write sits in the output register
      cyc(1'b1, 4'hF, 5'd3, 32'h11111111, 1'b1, 4'hF, 5'd8, 32'h22222222, 1'b1, 1'b0, 1'b0);
      #1;
      resetn = 1'b0;
      #1;
      chk("async_reset_out", {grant_l, rf_we, rf_waddr, rf_wdata}, 42'd0);
      p_valid = 1'b0; l_valid = 1'b0;
      hold_a = 5'd0; hold_d = 32'd0;
      @(posedge clk);
      #2;
      resetn = 1'b1;
      #1;
      chk("post_reset_starving", 42'(starving), 42'd0);
      // Counter restarted: L must be refused 4 times before it is forced
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 4'hF, 5'd3, 32'h11111111 + i, 1'b1, 4'hF, 5'd8, 32'h22222222, 1'b1, 1'b0, 1'b0);
      end
      cyc(1'b1, 4'hF, 5'd3, 32'h11111115, 1'b1, 4'hF, 5'd8, 32'h22222222, 1'b0, 1'b1, 1'b1);
      idle();
      @(posedge clk);
      #3;
      chk("queue_drained", 42'(exp_q.size()), 42'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
